axi_write_adapter: RTL

- Downstream of the DMA controller's simplified write channel.
- Converts one write request (address, beat count, size, burst) plus a ready/valid data stream into AXI4 AW/W/B transactions on the off-chip DDR port.
- Splits long requests into legal AXI4 INCR bursts: at most MAX_BURST_BEATS beats each, and no burst crosses a 4 KB boundary.
- Reports completion and any error response to the requester.

---
 rtl/axi_write_adapter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axi_write_adapter.sv
// Turns one DMA write request plus a ready/valid data stream into AXI4 INCR bursts.
// Bursts are capped at MAX_BURST_BEATS and never cross a 4 KB boundary.
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready high
// S_AW   | presenting one burst address
// S_W    | passing beats of the current burst through to the W channel
// S_B    | waiting for the write response of the current burst
// S_DONE | one-cycle completion pulse
module axi_write_adapter #(
    parameter int AXI_AWIDTH      = 32,
    parameter int AXI_DWIDTH      = 32,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_ID          = 0,
    parameter int MAX_BURST_BEATS = 256
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [AXI_AWIDTH-1:0]     req_addr,
    input  logic [31:0]               req_len,
    input  logic [2:0]                req_size,
    input  logic [1:0]                req_burst,
    input  logic [AXI_DWIDTH-1:0]     wdata_in,
    input  logic                      wdata_valid,
    output logic                      wdata_ready,
    output logic [AXI_ID_WIDTH-1:0]   m_awid,
    output logic [AXI_AWIDTH-1:0]     m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [AXI_DWIDTH-1:0]     m_wdata,
    output logic [AXI_DWIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [AXI_ID_WIDTH-1:0]   m_bid,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic                      write_done,
    output logic                      write_error
);

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [AXI_AWIDTH-1:0]   addr_q;
    logic [2:0]              size_q;
    logic [32:0]             remaining_q;
    logic [8:0]              chunk_q;
    logic [8:0]              beat_q;
    logic                    error_q;

    logic                    req_fire, aw_fire, w_fire, b_fire, last_beat;
    logic [8:0]              chunk_m1;
    logic [32:0]             rem_init, rem_after;
    logic [15:0]             chunk_bytes;
    logic [AXI_AWIDTH-1:0]   addr_after;
    logic                    unused_ok;

    // Beats allowed from address a: bounded by what is left, the burst cap and the 4 KB page.
    function automatic logic [8:0] chunk_calc(input logic [AXI_AWIDTH-1:0] a,
                                              input logic [32:0] rem,
                                              input logic [2:0] sz);
        logic [12:0] room;
        logic [8:0]  c;
        room = (13'd4096 - {1'b0, a[11:0]}) >> sz;
        if (room == 13'd0) room = 13'd1;
        c = (room > 13'(MAX_BURST_BEATS)) ? 9'(MAX_BURST_BEATS) : room[8:0];
        if (rem < {24'd0, c}) c = rem[8:0];
        return c;
    endfunction

    assign req_fire    = (state_q == S_IDLE) & req_valid;
    assign aw_fire     = (state_q == S_AW) & m_awready;
    assign w_fire      = (state_q == S_W) & wdata_valid & m_wready;
    assign b_fire      = (state_q == S_B) & m_bvalid;
    assign chunk_m1    = chunk_q - 9'd1;
    assign last_beat   = (beat_q == chunk_m1);
    assign rem_init    = {1'b0, req_len} + 33'd1;
    assign rem_after   = remaining_q - {24'd0, chunk_q};
    assign chunk_bytes = {7'd0, chunk_q} << size_q;
    assign addr_after  = addr_q + AXI_AWIDTH'(chunk_bytes);
    assign unused_ok   = ^m_bid;

    assign m_awid      = AXI_ID_WIDTH'(AXI_ID);
    assign m_awaddr    = addr_q;
    assign m_awlen     = chunk_m1[7:0];
    assign m_awsize    = size_q;
    assign m_awburst   = BURST_INCR;
    assign m_wdata     = wdata_in;
    assign m_wstrb     = '1;
    assign write_error = error_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        wdata_ready = 1'b0;
        m_wlast     = 1'b0;
        m_bready    = 1'b0;
        write_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_fire) state_d = (req_burst == BURST_INCR) ? S_AW : S_DONE;
            end
            S_AW: begin
                m_awvalid = 1'b1;
                if (aw_fire) state_d = S_W;
            end
            S_W: begin
                m_wvalid    = wdata_valid;
                wdata_ready = m_wready;
                m_wlast     = last_beat;
                if (w_fire && last_beat) state_d = S_B;
            end
            S_B: begin
                m_bready = 1'b1;
                if (b_fire) state_d = (rem_after == 33'd0) ? S_DONE : S_AW;
            end
            S_DONE: begin
                write_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q      <= '0;
            size_q      <= '0;
            remaining_q <= '0;
            chunk_q     <= '0;
            beat_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (req_fire) begin
                    addr_q      <= req_addr;
                    size_q      <= req_size;
                    remaining_q <= rem_init;
                    chunk_q     <= chunk_calc(req_addr, rem_init, req_size);
                    error_q     <= (req_burst != BURST_INCR);
                end
                S_AW: if (aw_fire) beat_q <= '0;
                S_W:  if (w_fire) beat_q <= beat_q + 9'd1;
                S_B:  if (b_fire) begin
                    remaining_q <= rem_after;
                    addr_q      <= addr_after;
                    chunk_q     <= chunk_calc(addr_after, rem_after, size_q);
                    if (m_bresp != 2'b00) error_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
